// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
//
// Purpose:
//   APB initiator that converts single-beat CPU data-bus requests into APB
//   SETUP/ACCESS transfers toward up to NUM_SLV responders. The slave is chosen
//   from the address. The bridge waits on the selected PREADY and then returns
//   read data with a one-cycle completion pulse. Addresses outside the APB
//   region, or with a slave index of NUM_SLV or more, complete at once with
//   err=1 and cause no bus activity.
//
// Optional feature:
//   APB_TIMEOUT_EN - when defined, an ACCESS phase that sees no PREADY for
//   TIMEOUT_CYC cycles is aborted and completes with err=1. When undefined,
//   ACCESS waits for PREADY with no limit.
//
// Ports:
//   PCLK      in   clock, rising edge
//   PRESET    in   asynchronous active-high reset
//   transfer  in   request strobe, sampled only while idle
//   addr      in   [31:0] request byte address
//   write     in   1 = write, 0 = read
//   wdata     in   [31:0] write data
//   rdata     out  [31:0] read data, valid while ready=1, held until next completion
//   ready     out  one-cycle completion pulse
//   err       out  error flag, valid while ready=1
//   busy      out  transfer in progress
//   PADDR     out  [31:0] APB address
//   PWRITE    out  APB direction
//   PENABLE   out  APB access phase
//   PWDATA    out  [31:0] APB write data
//   PSEL      out  [NUM_SLV-1:0] one-hot slave select
//   PRDATA    in   [NUM_SLV*32-1:0] packed slave read data, slave i at [32*i+:32]
//   PREADY    in   [NUM_SLV-1:0] per-slave ready
// -----------------------------------------------------------------------------
module apb_master_bridge #(
  parameter int          NUM_SLV     = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          SLV_SHIFT   = 12,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic                   transfer,
  input  logic [31:0]            addr,
  input  logic                   write,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata,
  output logic                   ready,
  output logic                   err,
  output logic                   busy,
  output logic [31:0]            PADDR,
  output logic                   PWRITE,
  output logic                   PENABLE,
  output logic [31:0]            PWDATA,
  output logic [NUM_SLV-1:0]     PSEL,
  input  logic [NUM_SLV*32-1:0]  PRDATA,
  input  logic [NUM_SLV-1:0]     PREADY
);

  localparam int IDXW = $clog2(NUM_SLV);
  localparam int FW   = 16 - SLV_SHIFT;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t               r_state;
  logic [IDXW-1:0]      r_idx;
  logic [31:0]          r_paddr;
  logic                 r_pwrite;
  logic [31:0]          r_pwdata;
  logic                 r_penable;
  logic [NUM_SLV-1:0]   r_psel;
  logic [31:0]          r_rdata;
  logic                 r_ready;
  logic                 r_err;

  // Address decode. The slave-index field is every bit between SLV_SHIFT and
  // the region boundary, so indices beyond NUM_SLV-1 count as a miss instead
  // of aliasing onto a lower slave.
  logic [FW-1:0]        w_field;
  logic [IDXW-1:0]      w_idx;
  logic                 w_hit;
  logic [NUM_SLV-1:0]   w_onehot;

  assign w_field  = addr[15:SLV_SHIFT];
  assign w_idx    = addr[SLV_SHIFT +: IDXW];
  assign w_hit    = (addr[31:16] == BASE_ADDR[31:16]) &&
                    ({{(32-FW){1'b0}}, w_field} < 32'(NUM_SLV));
  assign w_onehot = {{(NUM_SLV-1){1'b0}}, 1'b1} << w_idx;

  // Only the selected slave's ready and data matter; other PREADY bits are
  // ignored.
  logic                 w_sel_ready;
  logic [31:0]          w_sel_rdata;

  assign w_sel_ready = PREADY[r_idx];
  assign w_sel_rdata = PRDATA[{r_idx, 5'b0} +: 32];

`ifdef APB_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYC - 1);
  logic [7:0]           r_cnt;
`else
  // The timeout limit only matters when the abort path is built.
  logic                 w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYC > 0);
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_paddr   <= '0;
      r_pwrite  <= 1'b0;
      r_pwdata  <= '0;
      r_penable <= 1'b0;
      r_psel    <= '0;
      r_rdata   <= '0;
      r_ready   <= 1'b0;
      r_err     <= 1'b0;
`ifdef APB_TIMEOUT_EN
      r_cnt     <= '0;
`endif
    end else begin
      // Completion is a single-cycle pulse.
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (transfer) begin
            if (w_hit) begin
              r_paddr  <= addr;
              r_pwrite <= write;
              r_pwdata <= wdata;
              r_idx    <= w_idx;
              r_psel   <= w_onehot;
              r_state  <= ST_SETUP;
            end else begin
              // Decode miss: complete immediately, no bus cycle.
              r_ready <= 1'b1;
              r_err   <= 1'b1;
              r_rdata <= '0;
            end
          end
        end

        ST_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ST_ACCESS;
`ifdef APB_TIMEOUT_EN
          r_cnt     <= '0;
`endif
        end

        ST_ACCESS: begin
          // PREADY takes priority over the timeout when both land together.
          if (w_sel_ready) begin
            r_rdata   <= r_pwrite ? 32'h0 : w_sel_rdata;
            r_ready   <= 1'b1;
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_state   <= ST_IDLE;
          end
`ifdef APB_TIMEOUT_EN
          else if (r_cnt == TO_LIMIT) begin
            r_rdata   <= '0;
            r_ready   <= 1'b1;
            r_err     <= 1'b1;
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_state   <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
`endif
        end

        default: begin
          r_psel    <= '0;
          r_penable <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign rdata   = r_rdata;
  assign ready   = r_ready;
  assign err     = r_err;
  assign busy    = (r_state != ST_IDLE);
  assign PADDR   = r_paddr;
  assign PWRITE  = r_pwrite;
  assign PENABLE = r_penable;
  assign PWDATA  = r_pwdata;
  assign PSEL    = r_psel;

endmodule

// File: tb/tb_apb_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_master_bridge
//
// Directed bench for apb_master_bridge with NUM_SLV=4. Each issued request
// pushes its expected completion (rdata, err, latency, PSEL pattern) onto a
// scoreboard queue. The entry is popped and compared when ready is seen. A
// small slave model answers PREADY after a programmable number of wait
// states per slave.
// -----------------------------------------------------------------------------
module tb_apb_master_bridge;

  localparam int NS = 4;

  logic              PCLK = 1'b0;
  logic              PRESET;
  logic              transfer;
  logic [31:0]       addr;
  logic              write;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ready;
  logic              err;
  logic              busy;
  logic [31:0]       PADDR;
  logic              PWRITE;
  logic              PENABLE;
  logic [31:0]       PWDATA;
  logic [NS-1:0]     PSEL;
  logic [NS*32-1:0]  PRDATA;
  logic [NS-1:0]     PREADY;

  apb_master_bridge #(
    .NUM_SLV    (NS),
    .BASE_ADDR  (32'h1000_0000),
    .SLV_SHIFT  (12),
    .TIMEOUT_CYC(16)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .transfer (transfer),
    .addr     (addr),
    .write    (write),
    .wdata    (wdata),
    .rdata    (rdata),
    .ready    (ready),
    .err      (err),
    .busy     (busy),
    .PADDR    (PADDR),
    .PWRITE   (PWRITE),
    .PENABLE  (PENABLE),
    .PWDATA   (PWDATA),
    .PSEL     (PSEL),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  // Slave model: acc_cnt counts ACCESS cycles of the current transfer
  // (0 in the first one). Slave i raises PREADY once acc_cnt >= swait[i].
  int            acc_cnt = 0;
  int            swait [NS];
  logic [31:0]   sdata [NS];
  logic [NS-1:0] force_rdy;

  always @(posedge PCLK) begin
    if ((PSEL != '0) && PENABLE) acc_cnt <= acc_cnt + 1;
    else                         acc_cnt <= 0;
  end

  always_comb begin
    PRDATA = '0;
    PREADY = force_rdy;
    for (int i = 0; i < NS; i++) begin
      PRDATA[32*i +: 32] = sdata[i];
      if (PSEL[i] && PENABLE && (acc_cnt >= swait[i])) PREADY[i] = 1'b1;
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic [NS-1:0] psel;
    int          issue;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a request at the current negedge and record its expected outcome.
  task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [31:0] er, input logic ee, input int el,
                       input logic [NS-1:0] ep);
    exp_t e;
    transfer = 1'b1;
    addr     = a;
    write    = w;
    wdata    = d;
    e.addr = a; e.wdata = d; e.write = w; e.rdata = er; e.err = ee;
    e.lat = el; e.psel = ep; e.issue = cyc;
    sbq.push_back(e);
    $display("issue addr=0x%08h write=%0d wdata=0x%08h", a, w, d);
  endtask

  // Step negedges until ready (bounded). Then pop the scoreboard and compare.
  // Optionally pulses a stray request inj_off cycles after issue.
  task automatic wait_done(input string tag, input int budget, input int inj_off,
                           input logic [31:0] inj_addr);
    exp_t e;
    int   n_psel;
    bit   apb_ok;
    bit   seen;
    int   lat;
    e = sbq[0];
    n_psel = 0;
    apb_ok = 1'b1;
    seen   = 1'b0;
    lat    = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge PCLK);
      transfer = 1'b0;
      if (inj_off >= 0 && (cyc - e.issue) == inj_off) begin
        transfer = 1'b1;
        addr     = inj_addr;
        write    = 1'b1;
        wdata    = 32'hDEAD_BEEF;
      end
      if (PSEL != '0) begin
        n_psel++;
        if (PSEL !== e.psel || PADDR !== e.addr || PWRITE !== e.write ||
            PWDATA !== e.wdata || PENABLE !== (n_psel > 1))
          apb_ok = 1'b0;
      end
      if (ready === 1'b1) begin
        seen = 1'b1;
        lat  = cyc - e.issue;
        if (PSEL !== '0 || PENABLE !== 1'b0 || busy !== 1'b0) apb_ok = 1'b0;
      end
    end
    if (!seen) begin
      chk({tag, "_ready_timeout"}, 64'(ready), 64'd1);
    end else begin
      chk({tag, "_rdata"}, 64'(rdata), 64'(e.rdata));
      chk({tag, "_err"},   64'(err),   64'(e.err));
      chk({tag, "_lat"},   64'(lat),   64'(e.lat));
      chk({tag, "_psel_cycles"}, 64'(n_psel), 64'((e.psel != '0) ? e.lat - 1 : 0));
      chk({tag, "_apb_phase"},   64'(apb_ok), 64'd1);
    end
    $display("done %s ready=%0d lat=%0d rdata=0x%08h err=%0d", tag, seen, lat, rdata, err);
    void'(sbq.pop_front());
  endtask

  initial begin
    int rdy_seen;
    PRESET    = 1'b1;
    transfer  = 1'b0;
    addr      = '0;
    write     = 1'b0;
    wdata     = '0;
    force_rdy = '0;
    swait[0] = 0; swait[1] = 1; swait[2] = 2; swait[3] = 0;
    sdata[0] = 32'h1234_5678; sdata[1] = 32'h1111_1111;
    sdata[2] = 32'h2222_2222; sdata[3] = 32'h3333_3333;

    repeat (3) @(negedge PCLK);
    chk("rst_psel",    64'(PSEL),    64'd0);
    chk("rst_penable", 64'(PENABLE), 64'd0);
    chk("rst_pwrite",  64'(PWRITE),  64'd0);
    chk("rst_paddr",   64'(PADDR),   64'd0);
    chk("rst_pwdata",  64'(PWDATA),  64'd0);
    chk("rst_rdata",   64'(rdata),   64'd0);
    chk("rst_ready",   64'(ready),   64'd0);
    chk("rst_err",     64'(err),     64'd0);
    chk("rst_busy",    64'(busy),    64'd0);
    PRESET = 1'b0;
    @(negedge PCLK);

    // Write to slave 1, one wait state: ready at T+4.
    issue(32'h1000_1004, 1'b1, 32'h0000_00A5, 32'h0, 1'b0, 4, 4'b0010);
    wait_done("wr_s1", 20, -1, 32'h0);

    // Zero-wait read from slave 0: ready at T+3.
    issue(32'h1000_0000, 1'b0, 32'hFFFF_0000, 32'h1234_5678, 1'b0, 3, 4'b0001);
    wait_done("rd_s0", 20, -1, 32'h0);

    // Region miss: immediate error completion, rdata cleared.
    issue(32'h2000_0000, 1'b0, 32'h0, 32'h0, 1'b1, 1, 4'b0000);
    wait_done("miss_region", 20, -1, 32'h0);

    // Two wait states on slave 2.
    issue(32'h1000_2010, 1'b0, 32'h0, 32'h2222_2222, 1'b0, 5, 4'b0100);
    wait_done("rd_s2", 20, -1, 32'h0);

    // Index 5 is beyond NUM_SLV: error completion.
    issue(32'h1000_5000, 1'b0, 32'h0, 32'h0, 1'b1, 1, 4'b0000);
    wait_done("miss_index", 20, -1, 32'h0);

    // Unselected slave 2 holds PREADY high; slave 3 needs 3 waits.
    swait[3]  = 3;
    force_rdy = 4'b0100;
    issue(32'h1000_3008, 1'b0, 32'h0, 32'h3333_3333, 1'b0, 6, 4'b1000);
    wait_done("rd_s3_unsel_rdy", 20, -1, 32'h0);
    force_rdy = '0;
    swait[3]  = 0;

    // Stray request during ACCESS is dropped. A request on the ready cycle
    // starts immediately.
    issue(32'h1000_2020, 1'b0, 32'h0, 32'h2222_2222, 1'b0, 5, 4'b0100);
    wait_done("busy_ignore", 20, 2, 32'h1000_3000);
    issue(32'h1000_3000, 1'b0, 32'h0, 32'h3333_3333, 1'b0, 3, 4'b1000);
    wait_done("back_to_back", 20, -1, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge PCLK);
      chk("not_queued", 64'({ready, busy, PSEL}), 64'd0);
    end

    // Reset in the second ACCESS cycle drops the transfer.
    swait[1] = 5;
    transfer = 1'b1; addr = 32'h1000_1000; write = 1'b0; wdata = 32'h0;
    @(negedge PCLK); transfer = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    chk("pre_reset_access", 64'({PSEL, PENABLE}), 64'({4'b0010, 1'b1}));
    PRESET = 1'b1;
    #1;
    chk("midrst_outputs", 64'({PSEL, PENABLE, PWRITE, ready, err, busy}), 64'd0);
    chk("midrst_paddr",   64'(PADDR), 64'd0);
    @(negedge PCLK);
    PRESET = 1'b0;
    rdy_seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge PCLK);
      if (ready === 1'b1) rdy_seen++;
    end
    chk("no_ready_after_reset", 64'(rdy_seen), 64'd0);
    swait[1] = 0;
    issue(32'h1000_1000, 1'b1, 32'h0000_005A, 32'h0, 1'b0, 3, 4'b0010);
    wait_done("post_reset_wr", 20, -1, 32'h0);

`ifdef APB_TIMEOUT_EN
    // PREADY never arrives: abort after 16 ACCESS cycles, ready at T+18.
    swait[1] = 1000;
    issue(32'h1000_1000, 1'b0, 32'h0, 32'h0, 1'b1, 18, 4'b0010);
    wait_done("timeout_abort", 40, -1, 32'h0);
    // PREADY on exactly the 16th ACCESS cycle completes normally.
    swait[1] = 15;
    issue(32'h1000_1000, 1'b0, 32'h0, 32'h1111_1111, 1'b0, 18, 4'b0010);
    wait_done("timeout_edge_ok", 40, -1, 32'h0);
    swait[1] = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
